mem_arbiter: RTL and testbench

Shares the single memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). Each requester uses a valid/ready request channel and receives a one-cycle response pulse. One transaction is outstanding at a time. A per-transaction timeout guarantees that every accepted request gets a response, even when the memory never answers.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_timeout.sv | 28 ++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IFU/LSU memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    localparam logic [63:0] ERR_RDATA   = '0;
    localparam int          TIMEOUT_DEF = 256;
    localparam int          CNT_W_DEF   = $clog2(TIMEOUT_DEF);

endpackage

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - per-transaction cycle counter with clear/enable and expire flag
module mem_arb_timeout #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = mem_arb_pkg::CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Only meaningful while a transaction is in flight; idle cycles never expire.
    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU single-port memory arbiter with timeout; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    owner_t              r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;
    logic                r_ifu_resp_valid;
    logic [DATA_W-1:0]   r_ifu_rdata;
    logic                r_ifu_resp_err;
    logic                r_lsu_resp_valid;
    logic [DATA_W-1:0]   r_lsu_rdata;
    logic                r_lsu_resp_err;
`ifdef MEM_ARB_RR_EN
    owner_t              r_last_owner;
`endif

    logic              w_idle;
    logic              w_busy;
    logic              w_grant_ifu;
    logic              w_grant_lsu;
    logic              w_accept;
    logic              w_expire;
    logic              w_done;
    logic              w_tmo;
    logic [DATA_W-1:0] w_resp_data;

    assign w_idle = (r_state == ST_IDLE) && !rst;
    assign w_busy = (r_state == ST_REQ) || (r_state == ST_RESP);

    always_comb begin
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        if (w_idle) begin
`ifdef MEM_ARB_RR_EN
            if (ifu_req_valid && lsu_req_valid) begin
                w_grant_ifu = (r_last_owner == OWN_LSU);
                w_grant_lsu = (r_last_owner == OWN_IFU);
            end else begin
                w_grant_ifu = ifu_req_valid;
                w_grant_lsu = lsu_req_valid;
            end
`else
            w_grant_lsu = lsu_req_valid;
            w_grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif
        end
    end

    assign w_accept      = w_grant_ifu || w_grant_lsu;
    assign ifu_req_ready = w_grant_ifu;
    assign lsu_req_ready = w_grant_lsu;

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_accept),
        .i_en     (w_busy),
        .o_expire (w_expire)
    );

    // A real response in the expiring cycle takes precedence over the timeout.
    assign w_done      = (r_state == ST_RESP) && mem_resp_valid;
    assign w_tmo       = w_expire && !w_done;
    assign w_resp_data = w_tmo ? ERR_RDATA[DATA_W-1:0] : (r_wen ? '0 : mem_rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_owner          <= OWN_IFU;
            r_addr           <= '0;
            r_wen            <= 1'b0;
            r_wdata          <= '0;
            r_wmask          <= '0;
            r_ifu_resp_valid <= 1'b0;
            r_ifu_rdata      <= '0;
            r_ifu_resp_err   <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_rdata      <= '0;
            r_lsu_resp_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_owner     <= OWN_IFU;
`endif
        end else begin
            r_ifu_resp_valid <= 1'b0;
            r_ifu_resp_err   <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_resp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_REQ;
                        if (w_grant_lsu) begin
                            r_owner <= OWN_LSU;
                            r_addr  <= lsu_addr;
                            r_wen   <= lsu_wen;
                            r_wdata <= lsu_wdata;
                            r_wmask <= lsu_wmask;
                        end else begin
                            r_owner <= OWN_IFU;
                            r_addr  <= ifu_addr;
                            r_wen   <= 1'b0;
                            r_wdata <= '0;
                            r_wmask <= '0;
                        end
`ifdef MEM_ARB_RR_EN
                        r_last_owner <= w_grant_lsu ? OWN_LSU : OWN_IFU;
`endif
                    end
                end
                ST_REQ, ST_RESP: begin
                    if (w_done || w_tmo) begin
                        r_state <= ST_IDLE;
                        if (r_owner == OWN_IFU) begin
                            r_ifu_resp_valid <= 1'b1;
                            r_ifu_rdata      <= w_resp_data;
                            r_ifu_resp_err   <= w_tmo;
                        end else begin
                            r_lsu_resp_valid <= 1'b1;
                            r_lsu_rdata      <= w_resp_data;
                            r_lsu_resp_err   <= w_tmo;
                        end
                    end else if ((r_state == ST_REQ) && mem_req_ready) begin
                        r_state <= ST_RESP;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_valid  = (r_state == ST_REQ);
    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;
    assign ifu_resp_valid = r_ifu_resp_valid;
    assign ifu_rdata      = r_ifu_rdata;
    assign ifu_resp_err   = r_ifu_resp_err;
    assign lsu_resp_valid = r_lsu_resp_valid;
    assign lsu_rdata      = r_lsu_rdata;
    assign lsu_resp_err   = r_lsu_resp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (TIMEOUT=8)
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_resp_valid, ifu_resp_err;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [MW-1:0] lsu_wmask;
    logic          lsu_resp_valid, lsu_resp_err;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;

    int   n_total = 0;
    int   n_bad   = 0;
    logic first_lsu;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .ifu_resp_err   (ifu_resp_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_resp_err   (lsu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MEM_ARB_RR_EN
        first_lsu = 1'b0;
`else
        first_lsu = 1'b1;
`endif
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        next(); next(); mid();
        chk("rst_flags", 64'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, ifu_resp_err,
                              lsu_resp_valid, lsu_resp_err, mem_req_valid, mem_wen}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        next(); rst = 1'b0;

        // LSU read, memory answers immediately
        mem_req_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0010; lsu_wen = 1'b0;
        mid();
        chk("t1_ready", 64'({lsu_req_ready, ifu_req_ready}), 64'b10);
        next(); lsu_req_valid = 1'b0;
        mid();
        chk("t1_mem_req", 64'({mem_req_valid, mem_wen}), 64'b10);
        chk("t1_mem_addr", 64'(mem_addr), 64'h8000_0010);
        next(); mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        mid();
        chk("t1_c2_resp", 64'({lsu_resp_valid, ifu_resp_valid, mem_req_valid}), 64'd0);
        next(); mem_resp_valid = 1'b0;
        mid();
        chk("t1_c3_resp", 64'({lsu_resp_valid, lsu_resp_err, ifu_resp_valid}), 64'b100);
        chk("t1_rdata", 64'(lsu_rdata), 64'h1234_5678);
        next(); mid();
        chk("t1_pulse_end", 64'(lsu_resp_valid), 64'd0);
        chk("t1_rdata_hold", 64'(lsu_rdata), 64'h1234_5678);

        // both valid in IDLE; last owner was LSU
        next();
        ifu_req_valid = 1'b1; ifu_addr = 32'h100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h200; lsu_wen = 1'b0;
        mid();
        chk("t2_first_rdy", 64'({ifu_req_ready, lsu_req_ready}), first_lsu ? 64'b01 : 64'b10);
        next();
        if (first_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        mid();
        chk("t2_a_addr", 64'(mem_addr), first_lsu ? 64'h200 : 64'h100);
        chk("t2_busy_rdy", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
        next(); mem_resp_valid = 1'b1; mem_rdata = 32'hAAAA_0001;
        next(); mem_resp_valid = 1'b0;
        mid();
        chk("t2_a_resp", 64'({ifu_resp_valid, lsu_resp_valid}), first_lsu ? 64'b01 : 64'b10);
        chk("t2_b_rdy", 64'({ifu_req_ready, lsu_req_ready}), first_lsu ? 64'b10 : 64'b01);
        next(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mid();
        chk("t2_b_addr", 64'(mem_addr), first_lsu ? 64'h100 : 64'h200);
        next(); mem_resp_valid = 1'b1; mem_rdata = 32'hBBBB_0002;
        next(); mem_resp_valid = 1'b0;
        mid();
        chk("t2_b_resp", 64'({ifu_resp_valid, lsu_resp_valid}), first_lsu ? 64'b10 : 64'b01);
        chk("t2_ifu_rdata", 64'(ifu_rdata), first_lsu ? 64'hBBBB_0002 : 64'hAAAA_0001);

        // reset while in RESP discards the transaction
        next(); ifu_req_valid = 1'b1; ifu_addr = 32'h300;
        next(); ifu_req_valid = 1'b0;
        next(); rst = 1'b1;
        next(); rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h9999_9999;
        mid();
        chk("t6_flags", 64'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, ifu_resp_err,
                             lsu_resp_valid, lsu_resp_err, mem_req_valid, mem_wen}), 64'd0);
        chk("t6_rdata", 64'({ifu_rdata, lsu_rdata}), 64'd0);
        chk("t6_mem_addr", 64'(mem_addr), 64'd0);
        next(); mem_resp_valid = 1'b0;
        mid();
        chk("t6_no_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);

        // LSU write
        next();
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0100;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        mid();
        chk("t5_ready", 64'(lsu_req_ready), 64'd1);
        next(); lsu_req_valid = 1'b0; lsu_wen = 1'b0;
        mid();
        chk("t5_mem_req", 64'({mem_req_valid, mem_wen, mem_wmask}), 64'b110011);
        chk("t5_mem_addr", 64'(mem_addr), 64'h8000_0100);
        chk("t5_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        next(); mem_resp_valid = 1'b1; mem_rdata = 32'h5555_5555;
        next(); mem_resp_valid = 1'b0;
        mid();
        chk("t5_resp", 64'({lsu_resp_valid, lsu_resp_err, ifu_resp_valid}), 64'b100);
        chk("t5_rdata", 64'(lsu_rdata), 64'd0);

        // IFU fetch with memory stalling 5 cycles
        next();
        mem_req_ready = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h4000;
        next(); ifu_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("t3_hold", 64'({mem_req_valid, mem_wen, mem_wmask, mem_addr}),
                64'({1'b1, 1'b0, 4'b0000, 32'h4000}));
            next();
        end
        mem_req_ready = 1'b1;
        next(); mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        mid();
        chk("t3_no_early", 64'(ifu_resp_valid), 64'd0);
        next(); mem_resp_valid = 1'b0;
        mid();
        chk("t3_resp", 64'({ifu_resp_valid, ifu_resp_err, lsu_resp_valid}), 64'b100);
        chk("t3_rdata", 64'(ifu_rdata), 64'hCAFE_F00D);

        // memory never answers: timeout
        next();
        mem_req_ready = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h5000;
        next(); ifu_req_valid = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            mid();
            chk("t4_wait", 64'({ifu_resp_valid, mem_req_valid}), 64'b01);
            next();
        end
        mid();
        chk("t4_tmo", 64'({ifu_resp_valid, ifu_resp_err, mem_req_valid, lsu_resp_valid}), 64'b1100);
        chk("t4_rdata", 64'(ifu_rdata), 64'd0);
        next(); mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
        mid();
        chk("t4_pulse_end", 64'(ifu_resp_valid), 64'd0);
        next(); mem_resp_valid = 1'b0;
        mid();
        chk("t4_stray", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
        chk("t4_rdata_hold", 64'(ifu_rdata), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
